// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests from pc_in, buffers {pc, instr}
// responses in a small FIFO for decode, and steers pc_next (+4 / hold / redirect).
module fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            misalign_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   disc_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;
  logic [AW-1:0]   of_wr;
  logic [AW-1:0]   of_rd;
  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic [XLEN-1:0] of_pc    [DEPTH];
  logic [XLEN-1:0] of_instr [DEPTH];

  logic [CW:0] credit_used;
  logic        grant;
  logic        resp_drop;
  logic        of_push;
  logic        of_pop;

  // Credits cover both in-flight requests and buffered entries, so the out FIFO cannot overflow.
  always_comb begin
    credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    imem_req    = rst & ~redirect & (credit_used < (CW+1)'(DEPTH));
    imem_addr   = pc_in;
    grant       = imem_req & imem_gnt;
    resp_drop   = imem_rvalid & (redirect | (disc_cnt != '0));
    of_push     = imem_rvalid & ~resp_drop;
    id_valid    = (fifo_cnt != '0);
    of_pop      = id_valid & id_ready;
    id_pc       = of_pc[of_rd];
    id_instr    = of_instr[of_rd];
    if (redirect) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (grant) begin
      pc_next = pc_in + XLEN'(4);
    end else begin
      pc_next = pc_in;
    end
  end

  // In-flight tracking: tag pointers, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      if (grant) tag_wr <= tag_wr + AW'(1);
      if (imem_rvalid) tag_rd <= tag_rd + AW'(1);
      out_cnt <= out_cnt + CW'(grant) - CW'(imem_rvalid);
      if (redirect) begin
        disc_cnt <= out_cnt - CW'(imem_rvalid);
      end else if (resp_drop) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
    end
  end

  // Output FIFO control; a redirect flushes it wholesale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      of_wr        <= '0;
      of_rd        <= '0;
      fifo_cnt     <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect & (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        of_wr    <= '0;
        of_rd    <= '0;
        fifo_cnt <= '0;
      end else begin
        if (of_push) of_wr <= of_wr + AW'(1);
        if (of_pop) of_rd <= of_rd + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(of_push) - CW'(of_pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= pc_in;
    if (of_push) begin
      of_pc[of_wr]    <= tag_mem[tag_rd];
      of_instr[of_wr] <= imem_rdata;
    end
  end

endmodule
